donut_uart_tx: RTL and testbench
================================

Name: donut_uart_tx

Overview:
- Serial output stage of the donut renderer. Consumes the ASCII character stream produced by the frame generator and buffers it in a small FIFO.
- Shifts each character out on a single UART line as 8N1, LSB first.
- Drives the uo_out TX pin of tt_um_a1k0n_serialdonut.

Parameters:
- DIVISOR, 417, clocks per UART bit (48 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, character buffer entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- char_data  input  8  ASCII character from the renderer.
- char_valid  input  1  char_data is valid this cycle.
- char_ready  output  1  block can accept a character this cycle.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: tx=1, busy=0, char_ready=1. FIFO is empty, FSM is in IDLE, baud counter=0, bit counter=0.
- Input handshake: a character is accepted on a rising edge when char_valid and char_ready are both high.
  - char_ready = !fifo_full, taken from registered state only.
  - A pop on the same edge does not make room for a push while full.
  - char_data must be held stable while char_valid is high and char_ready is low.
- FIFO: read/write pointers are one bit wider than log2(FIFO_DEPTH) and wrap naturally.
  - Empty when the pointers are equal.
  - Full when only the MSB differs.
  - Push and pop on the same edge while not full and not empty: occupancy is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into shift register sr, load baud counter, go to START. Otherwise stay.
  - START: tx=0 for DIVISOR clocks, then go to DATA with bit index 0.
  - DATA: tx=sr[0] for DIVISOR clocks, then shift sr right and increment the bit index. After bit 7, go to STOP.
  - STOP: tx=1 for DIVISOR clocks. On expiry, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- tx is driven from a register (glitch-free).
  - In IDLE and STOP, tx=1.
- Latency: character accepted into an empty FIFO, idle FSM, at edge E. Pop occurs at E+1 and tx falls after E+1. Frame length is exactly 10*DIVISOR clocks.
- Baud counter counts DIVISOR-1 down to 0. The bit ends when the counter reads 0.
- busy = (state != IDLE) || !fifo_empty.
- Reset mid-frame: the line returns to idle on the reset edge (tx=1). Buffered characters are discarded. No partial frame resumes after reset.

Optional Feature:
- UART_CRLF_EN.
- Defined: when the FIFO head is 0x0A, the FSM first transmits 0x0D without popping and sets an internal cr_done flag. It then pops and transmits 0x0A, clearing cr_done.
  - A 0x0D is never inserted before any other byte.
  - Reset clears cr_done.
- Undefined: bytes pass through unmodified, and cr_done logic is absent.

Decomposition:
- Package donut_uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A.
  - Function clog2 used for pointer widths.
- Sub-module donut_uart_fifo: synchronous FIFO with push/pop/full/empty, parameterised by width and depth, same clk/rst.
- The FSM, baud counter and shift register stay in donut_uart_tx.

Test Plan:
- Reset then idle; DIVISOR=4, FIFO_DEPTH=4.
  -> tx=1, busy=0, char_ready=1 for 100 cycles.
- Single byte: push 8'h41 ('A') at edge E.
  -> tx falls after E+1.
  -> Line samples at bit centres read 0,1,0,0,0,0,0,1,0,1 (start, LSB-first data, stop).
  -> Each bit lasts 4 clocks; busy deasserts 40 clocks after the fall.
- Back-to-back frames: push "@#" (8'h40, 8'h23).
  -> Second start bit begins on the clock immediately after the first stop bit ends.
  -> Decoded stream equals 8'h40, 8'h23.
- FIFO full: hold char_valid high with 6 bytes while idle.
  -> char_ready drops after 4 bytes are buffered (the first byte is popped one cycle after acceptance).
  -> No byte is lost or duplicated; decoded order equals push order.
- Reset mid-frame: assert rst during data bit 3 of 8'h55 with 2 bytes still queued.
  -> tx=1 after the reset edge and busy=0.
  -> No further frames after reset deasserts.
- UART_CRLF_EN defined: push 8'h2E then 8'h0A.
  -> Decoded stream is 8'h2E, 8'h0D, 8'h0A.
  -> Without the macro, the decoded stream is 8'h2E, 8'h0A.

Source files
------------

// File: rtl/donut_uart_pkg.sv
// Shared types and constants for the donut UART transmitter.
package donut_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Bits needed to index 'value' entries; evaluated at elaboration only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/donut_uart_fifo.sv
// Character buffer, no added latency (head visible while non-empty).
// Pushes are dropped while full and pops while empty; full/empty come from registered pointers only.
module donut_uart_fifo
  import donut_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra pointer MSB separates full (MSB differs) from empty (equal).
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/donut_uart_tx.sv
// 8N1 LSB-first UART transmitter with a small character FIFO; first start bit one clock after acceptance.
// char_ready = FIFO not full. Define UART_CRLF_EN to send CR ahead of every LF.
module donut_uart_tx
  import donut_uart_pkg::*;
#(
  parameter int DIVISOR    = 417,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [15:0] BAUD_LOAD = 16'(DIVISOR - 1);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [15:0] r_baud;
  logic [15:0] w_baud_nxt;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_sr;
  logic [7:0]  w_sr_nxt;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_load;
  logic        w_bit_end;
  logic        w_insert_cr;
  logic [7:0]  w_head;

`ifdef UART_CRLF_EN
  logic r_cr_done;
  logic w_cr_done_nxt;

  assign w_insert_cr = (w_head == ASCII_LF) && !r_cr_done;
`else
  assign w_insert_cr = 1'b0;
`endif

  donut_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (char_valid),
    .i_push_dat (char_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_bit_end  = (r_baud == 16'd0);
  assign char_ready = !w_full;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign tx         = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_sr    <= w_sr_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef UART_CRLF_EN
  always_ff @(posedge clk) begin
    if (rst) r_cr_done <= 1'b0;
    else     r_cr_done <= w_cr_done_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_sr_nxt    = r_sr;
    w_load      = 1'b0;
    w_pop       = 1'b0;
`ifdef UART_CRLF_EN
    w_cr_done_nxt = r_cr_done;
`endif
    case (r_state)
      IDLE: begin
        if (!w_empty) w_load = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_baud_nxt  = BAUD_LOAD;
          w_bit_nxt   = 3'd0;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = BAUD_LOAD;
          w_sr_nxt   = {1'b0, r_sr[7:1]};
          if (r_bit == 3'd7) w_state_nxt = STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) w_load = 1'b1;
          else          w_state_nxt = IDLE;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Starting a frame: an inserted CR leaves the LF at the FIFO head for the next frame.
    if (w_load) begin
      w_state_nxt = START;
      w_baud_nxt  = BAUD_LOAD;
      w_pop       = !w_insert_cr;
      w_sr_nxt    = w_insert_cr ? ASCII_CR : w_head;
`ifdef UART_CRLF_EN
      w_cr_done_nxt = w_insert_cr;
`endif
    end
  end

  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_sr_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_donut_uart_tx.sv
// Bench for donut_uart_tx: frame-level line model, line decoder and directed plus random stimulus.
module tb_donut_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_data = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       tx;
  logic       busy;

  always #5 clk = ~clk;

  donut_uart_tx #(
    .DIVISOR    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tx         (tx),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: buffered bytes, sent bytes and position inside the current frame.
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  int         m_cyc = -1;
  logic [7:0] m_byte = 8'h00;
  bit         m_cr = 1'b0;
  bit         m_started = 1'b0;
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_ready = 1'b1;

  always @(posedge clk) begin
    bit acc;
    bit start;
    acc   = char_valid && (mq.size() < DEPTH);
    start = 1'b0;
    if (rst) begin
      mq.delete();
      sent_q.delete();
      m_cyc = -1;
      m_cr  = 1'b0;
    end else begin
      if (m_cyc < 0) begin
        start = (mq.size() > 0);
      end else if (m_cyc == FRAME - 1) begin
        start = (mq.size() > 0);
        m_cyc = -1;
      end else begin
        m_cyc++;
      end
      if (start) begin
`ifdef UART_CRLF_EN
        if (mq[0] == 8'h0A && !m_cr) begin
          m_byte = 8'h0D;
          m_cr   = 1'b1;
        end else begin
          m_byte = mq.pop_front();
          m_cr   = 1'b0;
        end
`else
        m_byte = mq.pop_front();
`endif
        sent_q.push_back(m_byte);
        m_cyc = 0;
      end
      if (acc) mq.push_back(char_data);
    end
    if (m_cyc < 0)                exp_tx = 1'b1;
    else if (m_cyc / DIV == 0)    exp_tx = 1'b0;
    else if (m_cyc / DIV == 9)    exp_tx = 1'b1;
    else                          exp_tx = m_byte[m_cyc / DIV - 1];
    exp_busy  = (m_cyc >= 0) || (mq.size() > 0);
    exp_ready = (mq.size() < DEPTH);
    m_started = 1'b1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("tx_vs_model", tx, exp_tx);
      check("busy_vs_model", busy, exp_busy);
      check("ready_vs_model", char_ready, exp_ready);
    end
  end

  // Line decoder: samples each bit at its centre after a falling edge.
  int         ncyc = 0;
  int         rx_cnt = 0;
  bit         rx_act = 1'b0;
  logic       prev_tx = 1'b1;
  logic [9:0] rx_bits = '0;
  int         n_falls = 0;
  int         fall_log[$];
  logic [7:0] rx_log[$];
  logic [9:0] bits_log[$];

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (prev_tx && !tx) begin
        rx_act = 1'b1;
        rx_cnt = 0;
        n_falls++;
        fall_log.push_back(ncyc);
      end
    end else begin
      rx_cnt++;
    end
    if (rx_act && (rx_cnt % DIV) == DIV / 2) begin
      rx_bits[rx_cnt / DIV] = tx;
      if (rx_cnt / DIV == 9) begin
        rx_act = 1'b0;
        bits_log.push_back(rx_bits);
        rx_log.push_back(rx_bits[8:1]);
        check("stop_bit", tx, 1);
        if (sent_q.size() == 0) check("rx_frame_expected", sent_q.size(), 1);
        else                    check("rx_vs_model", rx_bits[8:1], sent_q.pop_front());
      end
    end
    prev_tx = tx;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  logic [7:0] push_q[$];
  int         first_block = -1;

  task automatic push_all();
    int i;
    int guard;
    i = 0;
    guard = 0;
    first_block = -1;
    while (i < push_q.size() && guard < 2000) begin
      @(negedge clk);
      #1;
      char_valid = 1'b1;
      char_data  = push_q[i];
      if (char_ready) i++;
      else if (first_block < 0) first_block = i;
      guard++;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    char_valid = 1'b0;
    check("push_complete", i, push_q.size());
  endtask

  task automatic wait_quiet(input string name);
    int k;
    k = 0;
    while ((busy || rx_act) && k < 5000) begin
      tick(1);
      k++;
    end
    check(name, int'(busy || rx_act), 0);
  endtask

  task automatic clear_logs();
    rx_log.delete();
    bits_log.delete();
    fall_log.delete();
  endtask

  initial begin
    int k;
    int f;
    int falls0;
    logic [7:0] exp_s[$];

    rst = 1'b1;
    tick(3);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_ready", char_ready, 1);
    end

    // Single byte 'A': accepted at E, line falls after E+1.
    clear_logs();
    @(negedge clk);
    #1;
    char_valid = 1'b1;
    char_data  = 8'h41;
    @(posedge clk);
    @(negedge clk);
    #1;
    char_valid = 1'b0;
    check("a_tx_before_pop", tx, 1);
    check("a_busy_after_accept", busy, 1);
    tick(1);
    check("a_tx_fall", tx, 0);
    k = 0;
    while (busy && k < 200) begin
      tick(1);
      k++;
    end
    check("a_busy_clocks", k, FRAME);
    wait_quiet("a_quiet");
    check("a_frames", bits_log.size(), 1);
    if (bits_log.size() >= 1) begin
      check("a_line_bits", bits_log[0], 10'b1010000010);
      check("a_byte", rx_log[0], 8'h41);
    end

    // Back-to-back frames.
    clear_logs();
    push_q = '{8'h40, 8'h23};
    push_all();
    wait_quiet("b2b_quiet");
    check("b2b_frames", rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      check("b2b_gap", fall_log[1] - fall_log[0], FRAME);
      check("b2b_byte0", rx_log[0], 8'h40);
      check("b2b_byte1", rx_log[1], 8'h23);
    end

    // FIFO full with valid held high.
    clear_logs();
    push_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    push_all();
    check("full_accepted_before_block", first_block, 5);
    wait_quiet("full_quiet");
    check("full_frames", rx_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_log.size()) check("full_order", rx_log[i], push_q[i]);
    end

    // Reset during data bit 3 of 0x55 with two bytes queued.
    clear_logs();
    push_q = '{8'h55, 8'hAA, 8'h0F};
    push_all();
    k = 0;
    while (fall_log.size() == 0 && k < 100) begin
      tick(1);
      k++;
    end
    check("rst_frame_started", fall_log.size(), 1);
    f = (fall_log.size() > 0) ? fall_log[0] : ncyc;
    k = 0;
    while (ncyc < f + 17 && k < 100) begin
      tick(1);
      k++;
    end
    check("rst_tx_bit3", tx, 0);
    rst = 1'b1;
    tick(1);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", char_ready, 1);
    rst = 1'b0;
    falls0 = n_falls;
    tick(200);
    check("rst_no_frames", n_falls - falls0, 0);
    check("rst_no_bytes", rx_log.size(), 0);
    check("rst_line_idle", tx, 1);

    // Line feed handling.
    clear_logs();
    push_q = '{8'h2E, 8'h0A};
    push_all();
    wait_quiet("lf_quiet");
`ifdef UART_CRLF_EN
    exp_s = '{8'h2E, 8'h0D, 8'h0A};
`else
    exp_s = '{8'h2E, 8'h0A};
`endif
    check("lf_frames", rx_log.size(), exp_s.size());
    for (int i = 0; i < exp_s.size(); i++) begin
      if (i < rx_log.size()) check("lf_byte", rx_log[i], exp_s[i]);
    end

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (i == 1500) begin
        char_valid = 1'b0;
        rst = 1'b1;
      end else if (i == 1501) begin
        rst = 1'b0;
      end else if (!(char_valid && !char_ready)) begin
        char_valid = ($urandom_range(0, 3) == 0);
        char_data  = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    #1;
    char_valid = 1'b0;
    wait_quiet("rand_quiet");
    check("rand_all_decoded", sent_q.size(), 0);
    check("rand_fifo_drained", mq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
